// File: rtl/adbg_resp_pkg.sv
// Shared constants for the core debug responder: register map, DMR/DSR bit
// positions, FSM state encoding and the default error read data.
package adbg_resp_pkg;

    localparam logic [15:0] ADDR_DMR = 16'h0000;
    localparam logic [15:0] ADDR_DSR = 16'h0001;
    localparam logic [15:0] ADDR_NPC = 16'h0002;
    localparam logic [15:0] ADDR_PPC = 16'h0003;

    localparam logic [15:0] GPR_BASE_DEF = 16'h0400;
    localparam int unsigned GPR_COUNT    = 32;

    localparam int DMR_HALT   = 0;
    localparam int DMR_STEP   = 1;
    localparam int DMR_RESUME = 2;

    localparam int DSR_HALTED  = 0;
    localparam int DSR_STEPPED = 1;
    localparam int DSR_ERROR   = 3;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GPR_REQ,
        ST_GPR_RD,
        ST_ACK,
        ST_TURN
    } state_e;

endpackage

// File: rtl/adbg_resp_timeout.sv
// GPR grant watchdog: counts cycles while run_i is high and flags the last
// permitted cycle. Built only when ADBG_RESP_TIMEOUT_EN is defined.
module adbg_resp_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;

    // Fires during the TIMEOUT_CYCLES-th waiting cycle so the caller can ack next
    assign expired_o = run_i && (cnt == LAST_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i) begin
            cnt <= '0;
        end else if (!expired_o) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adbg_core_dbg_resp.sv
// Debug-BIU slave for the core: DMR/DSR/NPC/PPC registers and a GPR window
// through the register-file port. Optional grant timeout: ADBG_RESP_TIMEOUT_EN.
module adbg_core_dbg_resp
    import adbg_resp_pkg::*;
#(
    parameter logic [15:0] GPR_BASE       = GPR_BASE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dbg_stb_i,
    input  logic        dbg_we_i,
    input  logic [15:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_ack_o,
    input  logic        core_halted_i,
    input  logic [31:0] core_npc_i,
    input  logic [31:0] core_ppc_i,
    output logic        core_halt_o,
    output logic        core_step_o,
    output logic        core_resume_o,
    output logic        core_npc_wr_o,
    output logic [31:0] core_npc_wdata_o,
    output logic        gpr_req_o,
    output logic        gpr_we_o,
    output logic [4:0]  gpr_addr_o,
    output logic [31:0] gpr_wdata_o,
    input  logic        gpr_gnt_i,
    input  logic [31:0] gpr_rdata_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_tmo_range
        $error("TIMEOUT_CYCLES must fit the 8-bit timeout counter (1..256)");
    end

    state_e      state;
    logic        dmr_halt;
    logic        dmr_step;
    logic        dsr_stepped;
    logic        dsr_error;
    logic        halted_q;
    logic [16:0] gpr_off;
    logic        in_gpr;
    logic        acc_idle;
    logic        dsr_wr;
    logic        stepped_set;
    logic        err_set;
    logic        tmo_expired;
    logic [31:0] reg_rdata;

`ifdef ADBG_RESP_TIMEOUT_EN
    adbg_resp_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run_i    (state == ST_GPR_REQ),
        .expired_o(tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    assign core_halt_o = dmr_halt;
    assign core_step_o = dmr_step;

    always_comb begin
        // 17-bit difference so addresses below the window wrap far out of range
        gpr_off     = {1'b0, dbg_addr_i} - {1'b0, GPR_BASE};
        in_gpr      = (gpr_off < 17'(GPR_COUNT));
        acc_idle    = (state == ST_IDLE) && dbg_stb_i;
        dsr_wr      = acc_idle && dbg_we_i && !in_gpr && (dbg_addr_i == ADDR_DSR);
        stepped_set = core_halted_i && !halted_q && dmr_step;
        err_set     = (acc_idle && in_gpr && !core_halted_i)
                   || ((state == ST_GPR_REQ) && !gpr_gnt_i && tmo_expired);

        reg_rdata = '0;
        case (dbg_addr_i)
            ADDR_DMR: begin
                reg_rdata[DMR_HALT] = dmr_halt;
                reg_rdata[DMR_STEP] = dmr_step;
            end
            ADDR_DSR: begin
                reg_rdata[DSR_HALTED]  = core_halted_i;
                reg_rdata[DSR_STEPPED] = dsr_stepped;
                reg_rdata[DSR_ERROR]   = dsr_error;
            end
            ADDR_NPC: reg_rdata = core_npc_i;
            ADDR_PPC: reg_rdata = core_ppc_i;
            default:  reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            dmr_halt      <= 1'b0;
            dmr_step      <= 1'b0;
            dsr_stepped   <= 1'b0;
            dsr_error     <= 1'b0;
            halted_q      <= 1'b0;
            dbg_ack_o     <= 1'b0;
            dbg_rdata_o   <= '0;
            core_resume_o <= 1'b0;
            core_npc_wr_o <= 1'b0;
            gpr_req_o     <= 1'b0;
            gpr_we_o      <= 1'b0;
            gpr_addr_o    <= '0;
            gpr_wdata_o   <= '0;
        end else begin
            dbg_ack_o     <= 1'b0;
            core_resume_o <= 1'b0;
            core_npc_wr_o <= 1'b0;
            halted_q      <= core_halted_i;

            // Set events take priority over a same-cycle write-1-to-clear
            if (stepped_set) begin
                dsr_stepped <= 1'b1;
            end else if (dsr_wr && dbg_wdata_i[DSR_STEPPED]) begin
                dsr_stepped <= 1'b0;
            end
            if (err_set) begin
                dsr_error <= 1'b1;
            end else if (dsr_wr && dbg_wdata_i[DSR_ERROR]) begin
                dsr_error <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (dbg_stb_i) begin
                        if (in_gpr && core_halted_i) begin
                            gpr_req_o   <= 1'b1;
                            gpr_we_o    <= dbg_we_i;
                            gpr_addr_o  <= gpr_off[4:0];
                            gpr_wdata_o <= dbg_wdata_i;
                            state       <= ST_GPR_REQ;
                        end else begin
                            dbg_ack_o <= 1'b1;
                            state     <= ST_ACK;
                            if (in_gpr) begin
                                if (!dbg_we_i) dbg_rdata_o <= ERR_RDATA;
                            end else if (!dbg_we_i) begin
                                dbg_rdata_o <= reg_rdata;
                            end else if (dbg_addr_i == ADDR_DMR) begin
                                dmr_halt      <= dbg_wdata_i[DMR_HALT];
                                dmr_step      <= dbg_wdata_i[DMR_STEP];
                                core_resume_o <= dbg_wdata_i[DMR_RESUME];
                            end else if (dbg_addr_i == ADDR_NPC) begin
                                core_npc_wr_o <= 1'b1;
                            end
                        end
                    end
                end
                ST_GPR_REQ: begin
                    if (gpr_gnt_i) begin
                        gpr_req_o <= 1'b0;
                        gpr_we_o  <= 1'b0;
                        if (gpr_we_o) begin
                            dbg_ack_o <= 1'b1;
                            state     <= ST_ACK;
                        end else begin
                            state <= ST_GPR_RD;
                        end
                    end else if (tmo_expired) begin
                        gpr_req_o <= 1'b0;
                        gpr_we_o  <= 1'b0;
                        dbg_ack_o <= 1'b1;
                        state     <= ST_ACK;
                        if (!gpr_we_o) dbg_rdata_o <= ERR_RDATA;
                    end
                end
                ST_GPR_RD: begin
                    dbg_rdata_o <= gpr_rdata_i;
                    dbg_ack_o   <= 1'b1;
                    state       <= ST_ACK;
                end
                ST_ACK:  state <= ST_TURN;
                ST_TURN: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NPC override data is pure datapath; only its strobe needs reset
    always_ff @(posedge clk_i) begin
        if ((state == ST_IDLE) && dbg_stb_i && dbg_we_i && !in_gpr && (dbg_addr_i == ADDR_NPC)) begin
            core_npc_wdata_o <= dbg_wdata_i;
        end
    end

endmodule

// File: tb/tb_adbg_core_dbg_resp.sv
// Directed bench for adbg_core_dbg_resp; includes the grant-timeout case when
// ADBG_RESP_TIMEOUT_EN is defined.
module tb_adbg_core_dbg_resp;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dbg_stb_i;
    logic        dbg_we_i;
    logic [15:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o;
    logic        core_halted_i;
    logic [31:0] core_npc_i;
    logic [31:0] core_ppc_i;
    logic        core_halt_o;
    logic        core_step_o;
    logic        core_resume_o;
    logic        core_npc_wr_o;
    logic [31:0] core_npc_wdata_o;
    logic        gpr_req_o;
    logic        gpr_we_o;
    logic [4:0]  gpr_addr_o;
    logic [31:0] gpr_wdata_o;
    logic        gpr_gnt_i;
    logic [31:0] gpr_rdata_i;

    adbg_core_dbg_resp dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dbg_stb_i       (dbg_stb_i),
        .dbg_we_i        (dbg_we_i),
        .dbg_addr_i      (dbg_addr_i),
        .dbg_wdata_i     (dbg_wdata_i),
        .dbg_rdata_o     (dbg_rdata_o),
        .dbg_ack_o       (dbg_ack_o),
        .core_halted_i   (core_halted_i),
        .core_npc_i      (core_npc_i),
        .core_ppc_i      (core_ppc_i),
        .core_halt_o     (core_halt_o),
        .core_step_o     (core_step_o),
        .core_resume_o   (core_resume_o),
        .core_npc_wr_o   (core_npc_wr_o),
        .core_npc_wdata_o(core_npc_wdata_o),
        .gpr_req_o       (gpr_req_o),
        .gpr_we_o        (gpr_we_o),
        .gpr_addr_o      (gpr_addr_o),
        .gpr_wdata_o     (gpr_wdata_o),
        .gpr_gnt_i       (gpr_gnt_i),
        .gpr_rdata_i     (gpr_rdata_i)
    );

    always #5 clk_i = ~clk_i;

`ifdef ADBG_RESP_TIMEOUT_EN
    localparam int PARK_CYC = 100;
`else
    localparam int PARK_CYC = 300;
`endif

    int          vec_cnt = 0;
    int          miscmp  = 0;
    int          ack_cnt = 0;
    int          req_cyc = 0;
    int          resume_cnt = 0;
    int          npc_wr_cnt = 0;
    logic [31:0] npc_wdata_seen = '0;
    logic        gnt_en = 1'b0;
    int          gnt_delay = 0;
    logic [31:0] gpr_data_val = '0;
    logic [4:0]  seen_addr = '0;
    logic        seen_we = 1'b0;
    logic [31:0] seen_wdata = '0;
    logic        ack_resume = 1'b0;
    logic [31:0] rd;
    int          lat;
    int          base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // One BIU access; hold keeps stb up for that many cycles after the ack cycle
    task automatic bus_acc(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                           input int hold, output logic [31:0] rdata, output int latency);
        dbg_stb_i   = 1'b1;
        dbg_we_i    = we;
        dbg_addr_i  = addr;
        dbg_wdata_i = wd;
        latency     = 0;
        rdata       = '0;
        for (int c = 1; c <= 400; c++) begin
            cyc();
            if (dbg_ack_o) begin
                latency    = c;
                rdata      = dbg_rdata_o;
                ack_resume = core_resume_o;
                break;
            end
        end
        for (int h = 0; h < hold; h++) cyc();
        dbg_stb_i = 1'b0;
        for (int h = hold; h < 2; h++) cyc();
    endtask

    always @(negedge clk_i) begin
        if (dbg_ack_o) ack_cnt++;
        if (gpr_req_o) req_cyc++;
        if (core_resume_o) resume_cnt++;
        if (core_npc_wr_o) begin
            npc_wr_cnt++;
            npc_wdata_seen = core_npc_wdata_o;
        end
    end

    // Register-file model: grant gnt_delay cycles after req, data the cycle after
    initial begin
        int  age;
        logic gnt_prev;
        age = 0;
        gnt_prev = 1'b0;
        gpr_gnt_i = 1'b0;
        gpr_rdata_i = 32'h0BAD0BAD;
        forever begin
            cyc();
            gpr_rdata_i = gnt_prev ? gpr_data_val : 32'h0BAD0BAD;
            gnt_prev = 1'b0;
            gpr_gnt_i = 1'b0;
            if (gpr_req_o && gnt_en) begin
                if (age == gnt_delay) begin
                    gpr_gnt_i  = 1'b1;
                    gnt_prev   = 1'b1;
                    seen_addr  = gpr_addr_o;
                    seen_we    = gpr_we_o;
                    seen_wdata = gpr_wdata_o;
                    age = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        dbg_stb_i = 1'b0;
        dbg_we_i = 1'b0;
        dbg_addr_i = '0;
        dbg_wdata_i = '0;
        core_halted_i = 1'b1;
        core_npc_i = 32'h2000_0100;
        core_ppc_i = 32'h2000_00FC;
        repeat (3) cyc();
        rst_i = 1'b0;

        chk("rst_ack", {31'b0, dbg_ack_o}, 32'h0);
        chk("rst_rdata", dbg_rdata_o, 32'h0);
        chk("rst_ctl", {26'b0, core_halt_o, core_step_o, core_resume_o, core_npc_wr_o, gpr_req_o, gpr_we_o}, 32'h0);
        chk("rst_gpr", {gpr_addr_o, gpr_wdata_o[26:0]} | {5'b0, gpr_wdata_o[31:5]}, 32'h0);

        bus_acc(1'b1, 16'h0000, 32'h1, 0, rd, lat);
        chk("dmr_wr_lat", 32'(lat), 32'd1);
        chk("halt_o", {31'b0, core_halt_o}, 32'h1);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("dsr_rd_lat", 32'(lat), 32'd1);
        chk("dsr_halted", rd, 32'h1);
        bus_acc(1'b0, 16'h0000, 32'h0, 0, rd, lat);
        chk("dmr_rd", rd, 32'h1);

        gnt_en = 1'b1;
        gnt_delay = 3;
        gpr_data_val = 32'h1234_5678;
        bus_acc(1'b0, 16'h0405, 32'h0, 0, rd, lat);
        chk("gpr_rd_lat", 32'(lat), 32'd6);
        chk("gpr_rd_data", rd, 32'h1234_5678);
        chk("gpr_rd_addr", {27'b0, seen_addr}, 32'd5);
        chk("gpr_rd_we", {31'b0, seen_we}, 32'h0);
        chk("gpr_req_drop", {31'b0, gpr_req_o}, 32'h0);

        gnt_delay = 0;
        bus_acc(1'b1, 16'h041F, 32'hCAFE_F00D, 0, rd, lat);
        chk("gpr_wr_lat", 32'(lat), 32'd2);
        chk("gpr_wr_addr", {27'b0, seen_addr}, 32'd31);
        chk("gpr_wr_we", {31'b0, seen_we}, 32'h1);
        chk("gpr_wr_data", seen_wdata, 32'hCAFE_F00D);

        bus_acc(1'b1, 16'h0002, 32'h1000_0040, 0, rd, lat);
        chk("npc_wr_cnt", 32'(npc_wr_cnt), 32'd1);
        chk("npc_wdata", npc_wdata_seen, 32'h1000_0040);
        bus_acc(1'b0, 16'h0002, 32'h0, 0, rd, lat);
        chk("npc_rd", rd, 32'h2000_0100);
        bus_acc(1'b0, 16'h0003, 32'h0, 0, rd, lat);
        chk("ppc_rd", rd, 32'h2000_00FC);

        bus_acc(1'b1, 16'h0000, 32'h5, 0, rd, lat);
        chk("resume_at_ack", {31'b0, ack_resume}, 32'h1);
        chk("resume_cnt1", 32'(resume_cnt), 32'd1);
        chk("halt_kept", {31'b0, core_halt_o}, 32'h1);
        bus_acc(1'b1, 16'h0000, 32'h4, 0, rd, lat);
        chk("resume_cnt2", 32'(resume_cnt), 32'd2);
        chk("halt_cleared", {31'b0, core_halt_o}, 32'h0);
        bus_acc(1'b0, 16'h0000, 32'h0, 0, rd, lat);
        chk("dmr_resume_rd0", rd, 32'h0);

        bus_acc(1'b1, 16'h0000, 32'h2, 0, rd, lat);
        chk("step_o", {31'b0, core_step_o}, 32'h1);
        core_halted_i = 1'b0;
        repeat (2) cyc();
        core_halted_i = 1'b1;
        repeat (2) cyc();
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("dsr_stepped", rd, 32'h3);
        bus_acc(1'b1, 16'h0001, 32'h2, 0, rd, lat);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("dsr_step_w1c", rd, 32'h1);

        // Halt edge and the W1C write land on the same clock edge
        core_halted_i = 1'b0;
        repeat (2) cyc();
        core_halted_i = 1'b1;
        bus_acc(1'b1, 16'h0001, 32'h2, 0, rd, lat);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("dsr_set_wins", rd, 32'h3);
        bus_acc(1'b1, 16'h0001, 32'h2, 0, rd, lat);

        bus_acc(1'b1, 16'h0000, 32'h0, 0, rd, lat);
        core_halted_i = 1'b0;
        cyc();
        base = req_cyc;
        bus_acc(1'b0, 16'h0400, 32'h0, 0, rd, lat);
        chk("err_lat", 32'(lat), 32'd1);
        chk("err_rdata", rd, 32'hDEAD_BEEF);
        chk("err_no_req", 32'(req_cyc - base), 32'd0);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("dsr_err", rd, 32'h8);
        bus_acc(1'b1, 16'h0001, 32'h8, 0, rd, lat);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("dsr_err_w1c", rd, 32'h0);

        bus_acc(1'b1, 16'h0200, 32'hFFFF_FFFF, 0, rd, lat);
        chk("unmap_wr_lat", 32'(lat), 32'd1);
        bus_acc(1'b0, 16'h0123, 32'h0, 0, rd, lat);
        chk("unmap_rd", rd, 32'h0);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("unmap_no_err", rd, 32'h0);
        core_halted_i = 1'b1;
        base = req_cyc;
        bus_acc(1'b0, 16'h0420, 32'h0, 0, rd, lat);
        chk("above_win_rd", rd, 32'h0);
        bus_acc(1'b0, 16'h03FF, 32'h0, 0, rd, lat);
        chk("below_win_rd", rd, 32'h0);
        chk("edge_no_req", 32'(req_cyc - base), 32'd0);

        // stb stays up through the ACK and TURN cycles
        base = ack_cnt;
        bus_acc(1'b0, 16'h0001, 32'h0, 2, rd, lat);
        repeat (4) cyc();
        chk("one_ack", 32'(ack_cnt - base), 32'd1);
        chk("hold_rd", rd, 32'h1);

`ifdef ADBG_RESP_TIMEOUT_EN
        gnt_en = 1'b0;
        bus_acc(1'b0, 16'h0402, 32'h0, 0, rd, lat);
        chk("tmo_lat", 32'(lat), 32'd256);
        chk("tmo_rdata", rd, 32'hDEAD_BEEF);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
        chk("tmo_dsr", rd, 32'h9);
        bus_acc(1'b1, 16'h0001, 32'h8, 0, rd, lat);
        bus_acc(1'b0, 16'h0001, 32'h0, 0, rd, lat);
`endif

        gnt_en = 1'b0;
        base = ack_cnt;
        dbg_stb_i = 1'b1;
        dbg_we_i = 1'b0;
        dbg_addr_i = 16'h0401;
        repeat (PARK_CYC) cyc();
        chk("park_req", {31'b0, gpr_req_o}, 32'h1);
        chk("park_no_ack", 32'(ack_cnt - base), 32'd0);
        rst_i = 1'b1;
        dbg_stb_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        chk("midrst_req", {31'b0, gpr_req_o}, 32'h0);
        chk("midrst_rdata", dbg_rdata_o, 32'h0);
        repeat (5) cyc();
        chk("midrst_no_ack", 32'(ack_cnt - base), 32'd0);
        core_ppc_i = 32'h3000_0008;
        bus_acc(1'b0, 16'h0003, 32'h0, 0, rd, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_ppc", rd, 32'h3000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
